// File: rtl/bram_axil_controller_if.sv
// AXI4-Lite bundle between an SoC master and the BRAM controller slave.
// awprot/arprot are carried for completeness; the slave does not decode them.
interface bram_axil_controller_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   s_awaddr;
  logic [2:0]          s_awprot;
  logic                s_awvalid;
  logic                s_awready;
  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_wvalid;
  logic                s_wready;
  logic [1:0]          s_bresp;
  logic                s_bvalid;
  logic                s_bready;
  logic [ADDR_W-1:0]   s_araddr;
  logic [2:0]          s_arprot;
  logic                s_arvalid;
  logic                s_arready;
  logic [DATA_W-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rvalid;
  logic                s_rready;

  modport master (
    output s_awaddr, s_awprot, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arprot, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awprot, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arprot, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/bram_axil_controller.sv
// AXI4-Lite slave onto a single-port BRAM: read 2 cycles, full write 2, partial (RMW) write 3, out-of-window 1, plus BRAM waits.
// AW/W latch independently; B/R are held until bready/rready; reads and writes alternate on ties.
module bram_axil_controller #(
  parameter int              DATA_W    = 32,
  parameter int              ADDR_W    = 32,
  parameter longint unsigned BASE_ADDR = 0,
  parameter longint unsigned MEM_BYTES = 65536
) (
  input  logic                  clk,
  input  logic                  res_n,
  bram_axil_controller_if.slave axi,
  output logic [ADDR_W-1:0]     bram_addr,
  output logic [DATA_W-1:0]     bram_wdata,
  input  logic [DATA_W-1:0]     bram_rdata,
  output logic                  bram_read,
  output logic                  bram_write,
  input  logic                  bram_done
);
  localparam int              STRB_W = DATA_W / 8;
  localparam int              LSB    = $clog2(STRB_W);
  localparam logic [ADDR_W:0] BASE_L = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] MEM_L  = (ADDR_W+1)'(MEM_BYTES);

  typedef enum logic [2:0] {IDLE, RMW_READ, WRITE, WRITE_RESP, READ, READ_RESP} state_t;

  state_t              state;
  logic                aw_held, w_held, prio_wr;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;

  logic                aw_hs, w_hs, ar_hs, aw_now, w_now;
  logic [ADDR_W-1:0]   awaddr_now;
  logic [DATA_W-1:0]   wdata_now;
  logic [STRB_W-1:0]   wstrb_now;
  logic                unused_prot;

  // Offset is one bit wider so an address below the base wraps to a huge value and fails the window test.
  function automatic logic [ADDR_W:0] offset_of(input logic [ADDR_W-1:0] a);
    return {1'b0, a} - BASE_L;
  endfunction

  function automatic logic in_window(input logic [ADDR_W-1:0] a);
    return offset_of(a) < MEM_L;
  endfunction

  function automatic logic [ADDR_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return ADDR_W'(offset_of(a) >> LSB);
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_d,
                                              input logic [DATA_W-1:0] new_d,
                                              input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] m;
    m = old_d;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) m[8*i +: 8] = new_d[8*i +: 8];
    end
    return m;
  endfunction

  // Readies decode only state and flags; res_n keeps them low while in reset.
  assign axi.s_awready = res_n && (state == IDLE) && !aw_held;
  assign axi.s_wready  = res_n && (state == IDLE) && !w_held;
  assign axi.s_arready = res_n && (state == IDLE) && !(aw_held && w_held && prio_wr);

  assign aw_hs = axi.s_awvalid && axi.s_awready;
  assign w_hs  = axi.s_wvalid  && axi.s_wready;
  assign ar_hs = axi.s_arvalid && axi.s_arready;

  // A pair completing on this edge is dispatched immediately, without an extra IDLE cycle.
  assign aw_now     = aw_held || aw_hs;
  assign w_now      = w_held  || w_hs;
  assign awaddr_now = aw_held ? awaddr_q : axi.s_awaddr;
  assign wdata_now  = w_held  ? wdata_q  : axi.s_wdata;
  assign wstrb_now  = w_held  ? wstrb_q  : axi.s_wstrb;

  assign unused_prot = ^{axi.s_awprot, axi.s_arprot};

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state        <= IDLE;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      prio_wr      <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      axi.s_bvalid <= 1'b0;
      axi.s_bresp  <= 2'b00;
      axi.s_rvalid <= 1'b0;
      axi.s_rresp  <= 2'b00;
      axi.s_rdata  <= '0;
      bram_addr    <= '0;
      bram_wdata   <= '0;
      bram_read    <= 1'b0;
      bram_write   <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awaddr_q <= axi.s_awaddr;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= axi.s_wdata;
        wstrb_q <= axi.s_wstrb;
      end
      case (state)
        IDLE: begin
          if (ar_hs) begin
            if (in_window(axi.s_araddr)) begin
              state     <= READ;
              bram_read <= 1'b1;
              bram_addr <= word_of(axi.s_araddr);
            end else begin
              state        <= READ_RESP;
              axi.s_rvalid <= 1'b1;
              axi.s_rresp  <= 2'b10;
              axi.s_rdata  <= '0;
            end
          end else if (aw_now && w_now) begin
            if (!in_window(awaddr_now)) begin
              state        <= WRITE_RESP;
              axi.s_bvalid <= 1'b1;
              axi.s_bresp  <= 2'b10;
            end else if (&wstrb_now) begin
              state      <= WRITE;
              bram_write <= 1'b1;
              bram_addr  <= word_of(awaddr_now);
              bram_wdata <= wdata_now;
            end else begin
              state     <= RMW_READ;
              bram_read <= 1'b1;
              bram_addr <= word_of(awaddr_now);
            end
          end
        end
        RMW_READ: if (bram_done) begin
          state      <= WRITE;
          bram_read  <= 1'b0;
          bram_write <= 1'b1;
          bram_wdata <= merge(bram_rdata, wdata_q, wstrb_q);
        end
        WRITE: if (bram_done) begin
          state        <= WRITE_RESP;
          bram_write   <= 1'b0;
          axi.s_bvalid <= 1'b1;
          axi.s_bresp  <= 2'b00;
        end
        WRITE_RESP: if (axi.s_bready) begin
          state        <= IDLE;
          axi.s_bvalid <= 1'b0;
          aw_held      <= 1'b0;
          w_held       <= 1'b0;
          prio_wr      <= 1'b0;
        end
        READ: if (bram_done) begin
          state        <= READ_RESP;
          bram_read    <= 1'b0;
          axi.s_rdata  <= bram_rdata;
          axi.s_rresp  <= 2'b00;
          axi.s_rvalid <= 1'b1;
        end
        READ_RESP: if (axi.s_rready) begin
          state        <= IDLE;
          axi.s_rvalid <= 1'b0;
          prio_wr      <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          bram_read  <= 1'b0;
          bram_write <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bram_axil_controller.sv
// Directed bench: one default-window controller on a wait-programmable BRAM model, one narrow-window controller for range checks.
module tb_bram_axil_controller;
  logic clk;
  logic res_n;
  int   tests = 0;
  int   fails = 0;

  bram_axil_controller_if #(.ADDR_W(32), .DATA_W(32)) axi0();
  bram_axil_controller_if #(.ADDR_W(32), .DATA_W(32)) axi1();

  logic [31:0] b0_addr, b0_wdata, b0_rdata, b1_addr, b1_wdata, b1_rdata;
  logic        b0_read, b0_write, b0_done, b1_read, b1_write, b1_done;

  bram_axil_controller #(.DATA_W(32), .ADDR_W(32), .BASE_ADDR(0), .MEM_BYTES(65536)) dut0 (
    .clk(clk), .res_n(res_n), .axi(axi0),
    .bram_addr(b0_addr), .bram_wdata(b0_wdata), .bram_rdata(b0_rdata),
    .bram_read(b0_read), .bram_write(b0_write), .bram_done(b0_done)
  );

  bram_axil_controller #(.DATA_W(32), .ADDR_W(32), .BASE_ADDR('h1000), .MEM_BYTES('h100)) dut1 (
    .clk(clk), .res_n(res_n), .axi(axi1),
    .bram_addr(b1_addr), .bram_wdata(b1_wdata), .bram_rdata(b1_rdata),
    .bram_read(b1_read), .bram_write(b1_write), .bram_done(b1_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: completes after bram_wait extra cycles.
  logic [31:0] mem [64];
  int bram_wait = 0;
  int wcnt = 0;
  int nrd = 0;
  int nwr = 0;
  int both_hi = 0;
  int b1_strobes = 0;

  assign b0_done  = (b0_read || b0_write) && (wcnt == bram_wait);
  assign b0_rdata = mem[b0_addr[5:0]];
  assign b1_done  = b1_read || b1_write;
  assign b1_rdata = 32'h12345678;

  always @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wcnt <= 0;
    end else if (b0_read || b0_write) begin
      if (b0_read && b0_write) both_hi <= both_hi + 1;
      if (b0_done) begin
        wcnt <= 0;
        if (b0_write) begin
          mem[b0_addr[5:0]] <= b0_wdata;
          nwr <= nwr + 1;
        end else begin
          nrd <= nrd + 1;
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  always @(posedge clk) if (b1_read || b1_write) b1_strobes <= b1_strobes + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int c;
    axi0.s_awaddr = a; axi0.s_wdata = d; axi0.s_wstrb = s;
    axi0.s_awvalid = 1'b1; axi0.s_wvalid = 1'b1;
    tick();
    axi0.s_awvalid = 1'b0; axi0.s_wvalid = 1'b0;
    c = 0;
    while (!axi0.s_bvalid && c < 20) begin tick(); c++; end
    tests++; if (axi0.s_bvalid !== 1'b1) begin fails++; $display("FAIL write_timeout got bvalid=%b expected 1", axi0.s_bvalid); end
    axi0.s_bready = 1'b1; tick(); axi0.s_bready = 1'b0;
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if ({axi0.s_awready, axi0.s_wready, axi0.s_arready} !== 3'b000) begin fails++; $display("FAIL reset_readys got %b expected 000", {axi0.s_awready, axi0.s_wready, axi0.s_arready}); end
    tests++; if ({axi0.s_bvalid, axi0.s_rvalid, b0_read, b0_write} !== 4'b0000) begin fails++; $display("FAIL reset_valids got %b expected 0000", {axi0.s_bvalid, axi0.s_rvalid, b0_read, b0_write}); end
    tests++; if ({b0_addr, b0_wdata, axi0.s_rdata, axi0.s_bresp, axi0.s_rresp} !== 100'd0) begin fails++; $display("FAIL reset_data got addr=%h wdata=%h rdata=%h expected 0", b0_addr, b0_wdata, axi0.s_rdata); end
    res_n = 1'b1;
    tick();
    tests++; if ({axi0.s_awready, axi0.s_wready, axi0.s_arready} !== 3'b111) begin fails++; $display("FAIL idle_readys got %b expected 111", {axi0.s_awready, axi0.s_wready, axi0.s_arready}); end
  endtask

  task automatic test_full_write_read();
    axi0.s_awaddr = 32'h10; axi0.s_wdata = 32'hDEADBEEF; axi0.s_wstrb = 4'hF;
    axi0.s_awvalid = 1'b1; axi0.s_wvalid = 1'b1;
    tick();
    axi0.s_awvalid = 1'b0; axi0.s_wvalid = 1'b0;
    tests++; if ({b0_write, b0_read} !== 2'b10) begin fails++; $display("FAIL full_wr_strobe got write,read=%b expected 10", {b0_write, b0_read}); end
    tests++; if (b0_addr !== 32'd4 || b0_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL full_wr_addr got addr=%h data=%h expected 4 deadbeef", b0_addr, b0_wdata); end
    tick();
    tests++; if (axi0.s_bvalid !== 1'b1 || axi0.s_bresp !== 2'b00) begin fails++; $display("FAIL full_wr_bvalid got bvalid=%b bresp=%b expected 1 00", axi0.s_bvalid, axi0.s_bresp); end
    axi0.s_bready = 1'b1; tick(); axi0.s_bready = 1'b0;
    tests++; if (axi0.s_bvalid !== 1'b0) begin fails++; $display("FAIL full_wr_bclear got %b expected 0", axi0.s_bvalid); end
    axi0.s_araddr = 32'h10; axi0.s_arvalid = 1'b1;
    tick();
    axi0.s_arvalid = 1'b0;
    tests++; if (b0_read !== 1'b1 || axi0.s_rvalid !== 1'b0) begin fails++; $display("FAIL read_c1 got read=%b rvalid=%b expected 1 0", b0_read, axi0.s_rvalid); end
    tick();
    tests++; if (axi0.s_rvalid !== 1'b1 || axi0.s_rdata !== 32'hDEADBEEF || axi0.s_rresp !== 2'b00) begin fails++; $display("FAIL read_c2 got rvalid=%b rdata=%h rresp=%b expected 1 deadbeef 00", axi0.s_rvalid, axi0.s_rdata, axi0.s_rresp); end
    axi0.s_rready = 1'b1; tick(); axi0.s_rready = 1'b0;
    tests++; if (axi0.s_rvalid !== 1'b0) begin fails++; $display("FAIL read_rclear got %b expected 0", axi0.s_rvalid); end
  endtask

  task automatic test_partial_write();
    int rd0, wr0;
    do_write(32'h14, 32'h11223344, 4'hF);
    rd0 = nrd; wr0 = nwr;
    axi0.s_awaddr = 32'h14; axi0.s_wdata = 32'hAABBCCDD; axi0.s_wstrb = 4'h6;
    axi0.s_awvalid = 1'b1; axi0.s_wvalid = 1'b1;
    tick();
    axi0.s_awvalid = 1'b0; axi0.s_wvalid = 1'b0;
    tests++; if ({b0_read, b0_write} !== 2'b10 || b0_addr !== 32'd5) begin fails++; $display("FAIL rmw_read got read,write=%b addr=%h expected 10 5", {b0_read, b0_write}, b0_addr); end
    tick();
    tests++; if ({b0_read, b0_write} !== 2'b01 || b0_wdata !== 32'h11BBCC44) begin fails++; $display("FAIL rmw_write got read,write=%b wdata=%h expected 01 11bbcc44", {b0_read, b0_write}, b0_wdata); end
    tests++; if (axi0.s_bvalid !== 1'b0) begin fails++; $display("FAIL rmw_early_b got %b expected 0", axi0.s_bvalid); end
    tick();
    tests++; if (axi0.s_bvalid !== 1'b1 || axi0.s_bresp !== 2'b00) begin fails++; $display("FAIL rmw_bvalid got bvalid=%b bresp=%b expected 1 00", axi0.s_bvalid, axi0.s_bresp); end
    axi0.s_bready = 1'b1; tick(); axi0.s_bready = 1'b0;
    tests++; if (nrd - rd0 != 1 || nwr - wr0 != 1) begin fails++; $display("FAIL rmw_counts got reads=%0d writes=%0d expected 1 1", nrd - rd0, nwr - wr0); end
    tests++; if (mem[5] !== 32'h11BBCC44) begin fails++; $display("FAIL rmw_mem got %h expected 11bbcc44", mem[5]); end
  endtask

  task automatic test_decoupled();
    logic early;
    early = 1'b0;
    axi0.s_wdata = 32'hCAFEF00D; axi0.s_wstrb = 4'hF; axi0.s_wvalid = 1'b1;
    tick();
    axi0.s_wvalid = 1'b0;
    tests++; if ({axi0.s_wready, axi0.s_awready} !== 2'b01) begin fails++; $display("FAIL decoup_ready got wready,awready=%b expected 01", {axi0.s_wready, axi0.s_awready}); end
    repeat (4) begin tick(); if (b0_write || b0_read) early = 1'b1; end
    tests++; if (early !== 1'b0) begin fails++; $display("FAIL decoup_early got strobe=%b expected 0", early); end
    axi0.s_awaddr = 32'h20; axi0.s_awvalid = 1'b1;
    tick();
    axi0.s_awvalid = 1'b0;
    tests++; if (b0_write !== 1'b1 || b0_addr !== 32'd8 || b0_wdata !== 32'hCAFEF00D) begin fails++; $display("FAIL decoup_write got write=%b addr=%h data=%h expected 1 8 cafef00d", b0_write, b0_addr, b0_wdata); end
    tick();
    tests++; if (axi0.s_bvalid !== 1'b1) begin fails++; $display("FAIL decoup_b got %b expected 1", axi0.s_bvalid); end
    axi0.s_bready = 1'b1; tick(); axi0.s_bready = 1'b0;
  endtask

  task automatic test_tie();
    logic [7:0] ord [4];
    logic [7:0] exp_ord [4];
    int n;
    exp_ord = '{"R", "W", "R", "W"};
    ord = '{"-", "-", "-", "-"};
    n = 0;
    axi0.s_awaddr = 32'h18; axi0.s_wdata = 32'h55AA55AA; axi0.s_wstrb = 4'hF; axi0.s_araddr = 32'h10;
    axi0.s_awvalid = 1'b1; axi0.s_wvalid = 1'b1; axi0.s_arvalid = 1'b1;
    axi0.s_rready = 1'b1; axi0.s_bready = 1'b1;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      if (axi0.s_rvalid) begin ord[n] = "R"; n++; end
      else if (axi0.s_bvalid) begin ord[n] = "W"; n++; end
    end
    axi0.s_awvalid = 1'b0; axi0.s_wvalid = 1'b0; axi0.s_arvalid = 1'b0;
    tick();
    axi0.s_rready = 1'b0; axi0.s_bready = 1'b0;
    tests++; if (n != 4) begin fails++; $display("FAIL tie_count got %0d expected 4", n); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (ord[i] !== exp_ord[i]) begin fails++; $display("FAIL tie_order[%0d] got %s expected %s", i, ord[i], exp_ord[i]); end
    end
    tests++; if (both_hi != 0) begin fails++; $display("FAIL one_strobe got %0d overlaps expected 0", both_hi); end
  endtask

  task automatic test_out_of_range();
    axi1.s_araddr = 32'h1100; axi1.s_arvalid = 1'b1;
    tick();
    axi1.s_arvalid = 1'b0;
    tests++; if (axi1.s_rvalid !== 1'b1 || axi1.s_rresp !== 2'b10 || axi1.s_rdata !== 32'd0) begin fails++; $display("FAIL oor_read got rvalid=%b rresp=%b rdata=%h expected 1 10 0", axi1.s_rvalid, axi1.s_rresp, axi1.s_rdata); end
    axi1.s_rready = 1'b1; tick(); axi1.s_rready = 1'b0;
    axi1.s_awaddr = 32'h0FFC; axi1.s_wdata = 32'h0; axi1.s_wstrb = 4'hF;
    axi1.s_awvalid = 1'b1; axi1.s_wvalid = 1'b1;
    tick();
    axi1.s_awvalid = 1'b0; axi1.s_wvalid = 1'b0;
    tests++; if (axi1.s_bvalid !== 1'b1 || axi1.s_bresp !== 2'b10) begin fails++; $display("FAIL oor_write got bvalid=%b bresp=%b expected 1 10", axi1.s_bvalid, axi1.s_bresp); end
    axi1.s_bready = 1'b1; tick(); axi1.s_bready = 1'b0;
    tests++; if (b1_strobes != 0) begin fails++; $display("FAIL oor_strobe got %0d strobe cycles expected 0", b1_strobes); end
    axi1.s_araddr = 32'h10FC; axi1.s_arvalid = 1'b1;
    tick();
    axi1.s_arvalid = 1'b0;
    tests++; if (b1_read !== 1'b1 || b1_addr !== 32'h3F) begin fails++; $display("FAIL edge_read got read=%b addr=%h expected 1 3f", b1_read, b1_addr); end
    tick();
    tests++; if (axi1.s_rvalid !== 1'b1 || axi1.s_rresp !== 2'b00 || axi1.s_rdata !== 32'h12345678) begin fails++; $display("FAIL edge_rdata got rvalid=%b rresp=%b rdata=%h expected 1 00 12345678", axi1.s_rvalid, axi1.s_rresp, axi1.s_rdata); end
    axi1.s_rready = 1'b1; tick(); axi1.s_rready = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc;
    bram_wait = 3;
    cyc = 0;
    axi0.s_araddr = 32'h14; axi0.s_arvalid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      cyc++;
      axi0.s_arvalid = 1'b0;
      if (axi0.s_rvalid) break;
    end
    tests++; if (axi0.s_rvalid !== 1'b1 || cyc != 5) begin fails++; $display("FAIL bp_latency got rvalid=%b at cycle %0d expected 1 at 5", axi0.s_rvalid, cyc); end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (axi0.s_rvalid !== 1'b1 || axi0.s_rdata !== 32'h11BBCC44) begin fails++; $display("FAIL bp_hold[%0d] got rvalid=%b rdata=%h expected 1 11bbcc44", i, axi0.s_rvalid, axi0.s_rdata); end
    end
    axi0.s_rready = 1'b1; tick(); axi0.s_rready = 1'b0;
    tests++; if (axi0.s_rvalid !== 1'b0) begin fails++; $display("FAIL bp_release got %b expected 0", axi0.s_rvalid); end
  endtask

  task automatic test_reset_mid();
    int wr0;
    logic saw_b;
    saw_b = 1'b0;
    wr0 = nwr;
    axi0.s_awaddr = 32'h1C; axi0.s_wdata = 32'h0BADF00D; axi0.s_wstrb = 4'hF;
    axi0.s_awvalid = 1'b1; axi0.s_wvalid = 1'b1;
    tick();
    axi0.s_awvalid = 1'b0; axi0.s_wvalid = 1'b0;
    tests++; if (b0_write !== 1'b1) begin fails++; $display("FAIL mid_write got %b expected 1", b0_write); end
    tick();
    res_n = 1'b0;
    #1;
    tests++; if ({b0_read, b0_write, axi0.s_bvalid, axi0.s_rvalid, axi0.s_awready, axi0.s_wready, axi0.s_arready} !== 7'd0) begin fails++; $display("FAIL mid_reset_ctl got %b expected 0000000", {b0_read, b0_write, axi0.s_bvalid, axi0.s_rvalid, axi0.s_awready, axi0.s_wready, axi0.s_arready}); end
    tests++; if ({b0_addr, b0_wdata, axi0.s_rdata} !== 96'd0) begin fails++; $display("FAIL mid_reset_data got addr=%h wdata=%h rdata=%h expected 0", b0_addr, b0_wdata, axi0.s_rdata); end
    repeat (2) @(posedge clk);
    #1;
    res_n = 1'b1;
    axi0.s_bready = 1'b1;
    repeat (6) begin tick(); if (axi0.s_bvalid) saw_b = 1'b1; end
    axi0.s_bready = 1'b0;
    tests++; if (saw_b !== 1'b0) begin fails++; $display("FAIL mid_no_b got bvalid seen=%b expected 0", saw_b); end
    tests++; if (nwr != wr0) begin fails++; $display("FAIL mid_no_commit got %0d writes expected 0", nwr - wr0); end
    bram_wait = 0;
  endtask

  initial begin
    res_n = 1'b0;
    axi0.s_awaddr = '0; axi0.s_awprot = '0; axi0.s_awvalid = 1'b0;
    axi0.s_wdata = '0; axi0.s_wstrb = '0; axi0.s_wvalid = 1'b0; axi0.s_bready = 1'b0;
    axi0.s_araddr = '0; axi0.s_arprot = '0; axi0.s_arvalid = 1'b0; axi0.s_rready = 1'b0;
    axi1.s_awaddr = '0; axi1.s_awprot = '0; axi1.s_awvalid = 1'b0;
    axi1.s_wdata = '0; axi1.s_wstrb = '0; axi1.s_wvalid = 1'b0; axi1.s_bready = 1'b0;
    axi1.s_araddr = '0; axi1.s_arprot = '0; axi1.s_arvalid = 1'b0; axi1.s_rready = 1'b0;
    test_reset();
    test_full_write_read();
    test_partial_write();
    test_decoupled();
    test_tie();
    test_out_of_range();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
